// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// FSM state encodings and the iteration count of the shift datapath.
package mips_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_CALC   = 2'b01,
    S_FINISH = 2'b10
  } mdu_state_e;

  localparam int MDU_ITER = 32;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-high reset
//   start, op        launch op (00 MULT, 01 MULTU, 10 DIV, 11 DIVU); IDLE only
//   srcA, srcB       rs / rt operands, sampled on the accepting edge
//   mthi, mtlo       write srcA into HI / LO while IDLE and not starting
//   busy             operation in progress
//   done             one-cycle pulse when HI/LO were written by an operation
//   hi, lo           HI / LO registers
// Operands are reduced to magnitudes on entry; the core iterates unsigned and
// the signs are re-applied in FINISH. Multiply and divide share one 64-bit
// working register.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2    = 2 * WIDTH;
  localparam int CNT_W = $clog2(MDU_ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_ITER - 1);

  mdu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             res_neg;  // negate product / quotient
  logic             rem_neg;  // negate remainder (dividend sign)
  logic [WIDTH:0]   mcand;    // multiplicand or divisor magnitude
  logic [W2-1:0]    work;     // mult: {partial, multiplier}; div: {rem, quot}

  // Operand magnitudes, WIDTH+1 bits so |most-negative| is exact.
  logic           signed_op, sign_a, sign_b, b_zero;
  logic [WIDTH:0] ext_a, ext_b, mag_a, mag_b;

  always_comb begin
    signed_op = ~op[0];
    sign_a    = signed_op & srcA[WIDTH-1];
    sign_b    = signed_op & srcB[WIDTH-1];
    b_zero    = (srcB == '0);
    ext_a     = {sign_a, srcA};
    ext_b     = {sign_b, srcB};
    mag_a     = sign_a ? -ext_a : ext_a;
    mag_b     = sign_b ? -ext_b : ext_b;
  end

  // One shift-add multiply step and one restoring divide step.
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next, div_next;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;

  always_comb begin
    mul_sum  = {1'b0, work[W2-1:WIDTH]} + (work[0] ? mcand : '0);
    mul_next = {mul_sum, work[WIDTH-1:1]};
    rem_sh   = {work[W2-1:WIDTH], work[WIDTH-1]};
    diff     = {1'b0, rem_sh} - {1'b0, mcand};
    // Borrow out means the trial subtraction failed: keep the shifted remainder.
    div_next = diff[WIDTH+1] ? {rem_sh[WIDTH-1:0], work[WIDTH-2:0], 1'b0}
                             : W2'({diff[WIDTH:0], work[WIDTH-2:0], 1'b1});
  end

  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  always_comb begin
    prod_fix = res_neg ? -work : work;
    quot_fix = res_neg ? -work[WIDTH-1:0] : work[WIDTH-1:0];
    rem_fix  = rem_neg ? -work[W2-1:WIDTH] : work[W2-1:WIDTH];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      mcand   <= '0;
      work    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            is_div  <= op[1];
            mcand   <= mag_b;
            work    <= W2'(mag_a);
            // Divide by zero keeps the all-ones quotient unsigned and lets the
            // remainder path hand back the original dividend.
            res_neg <= (sign_a ^ sign_b) & ~(op[1] & b_zero);
            rem_neg <= sign_a;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= S_CALC;
          end else begin
            if (mthi) hi <= srcA;
            if (mtlo) lo <= srcA;
          end
        end
        S_CALC: begin
          work <= is_div ? div_next : mul_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= S_FINISH;
        end
        S_FINISH: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized plus directed scoreboard bench for mult_div_unit.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] srcA, srcB;
  logic        busy, done;
  logic [31:0] hi, lo;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .srcA(srcA), .srcB(srcB), .mthi(mthi), .mtlo(mtlo),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] res;     // {hi, lo}
    int          acc_cyc; // cycle count just after the accepting edge
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0, passed = 0;
  int   busy_run = 0;

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: plain arithmetic on wide integers.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, qv, rv;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'b00: return 64'(sa * sb);
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        qv = sa / sb;
        rv = sa % sb;
        return {rv[31:0], qv[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding operation.
  always @(negedge clock) begin
    if (reset) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk({e.name, "_hi"}, {32'd0, hi}, {32'd0, e.res[63:32]});
          chk({e.name, "_lo"}, {32'd0, lo}, {32'd0, e.res[31:0]});
          chk({e.name, "_latency"}, 64'(cyc - e.acc_cyc), 64'd33);
          chk({e.name, "_busy_cycles"}, 64'(busy_run), 64'd33);
        end
        busy_run = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while ((busy || q.size() != 0) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      total++;
      $display("FAIL idle_timeout: got busy=%0b pending=%0d expected idle", busy, q.size());
      q.delete();
    end
  endtask

  task automatic issue(input string name, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    exp_t e;
    wait_idle();
    start = 1'b1; op = o; srcA = a; srcB = b;
    e.res = model(o, a, b); e.acc_cyc = cyc + 1; e.name = name;
    q.push_back(e);
    @(negedge clock);
    start = 1'b0;
    srcA = $urandom; srcB = $urandom; op = 2'($urandom);  // later changes must not matter
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; srcA = '0; srcB = '0;
    repeat (3) @(negedge clock);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;

    issue("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue("mult_neg", 2'b00, -32'sd3, 32'd7);
    issue("div_neg", 2'b10, -32'sd7, 32'd2);
    issue("divu_100_7", 2'b11, 32'd100, 32'd7);
    issue("divu_by0", 2'b11, 32'd5, 32'd0);
    issue("div_by0_neg", 2'b10, 32'hFFFF_FF00, 32'd0);
    issue("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    issue("mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000);

    // Move-to registers in IDLE.
    wait_idle();
    mthi = 1'b1; mtlo = 1'b1; srcA = 32'h55AA_33CC;
    @(negedge clock);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthi_mtlo_both", {hi, lo}, {32'h55AA_33CC, 32'h55AA_33CC});
    mthi = 1'b1; srcA = 32'h1234;
    @(negedge clock);
    mthi = 1'b0;
    chk("mthi_only", {hi, lo}, {32'h1234, 32'h55AA_33CC});

    // start beats mthi in the same cycle.
    begin
      exp_t e;
      start = 1'b1; mthi = 1'b1; op = 2'b00; srcA = 32'd5; srcB = 32'd6;
      e.res = model(2'b00, 32'd5, 32'd6); e.acc_cyc = cyc + 1; e.name = "start_vs_mthi";
      q.push_back(e);
      @(negedge clock);
      start = 1'b0; mthi = 1'b0;
      chk("start_wins_hi", {32'd0, hi}, {32'd0, 32'h1234});
    end

    // mtlo and a second start while busy are ignored.
    issue("busy_ignore", 2'b01, 32'hDEAD_BEEF, 32'h0000_1357);
    repeat (4) @(negedge clock);
    start = 1'b1; mtlo = 1'b1; mthi = 1'b1; op = 2'b11; srcA = 32'h0BAD_F00D; srcB = 32'd3;
    @(negedge clock);
    start = 1'b0; mtlo = 1'b0; mthi = 1'b0;

    // Reset in the middle of a divide.
    issue("div_aborted", 2'b10, 32'd1000, 32'd7);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    q.delete();
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    chk("abort_hilo_later", {hi, lo}, 64'd0);
    issue("after_abort", 2'b10, -32'sd1000, 32'd7);

    // Random mix, with zero / small / sign-edge operands sprinkled in.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      issue($sformatf("rand%0d", i), 2'($urandom), a, b);
    end
    wait_idle();
    repeat (3) @(negedge clock);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
